// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types, command bytes and helpers for the LCD write controller
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETUP     = 3'd1,
    PULSE     = 3'd2,
    HOLD      = 3'd3,
    EXEC      = 3'd4,
    INIT_WAIT = 3'd5
  } lcd_state_e;

  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_FUNC_8B2L = 8'h38;
  localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
  localparam logic [7:0] CMD_ENTRY_INC = 8'h06;

  localparam int INIT_LEN = 6;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data[7:2] == 6'd0) && (data != 8'd0);
  endfunction

endpackage

// File: rtl/lcd_ctrl_if.sv
// rtl/lcd_ctrl_if.sv - byte write handshake between the LSU side and the LCD controller
interface lcd_ctrl_if;

  logic       wr_vld;
  logic       wr_rs;
  logic [7:0] wr_data;
  logic       wr_rdy;
  logic       busy;

  modport master (
    output wr_vld, wr_rs, wr_data,
    input  wr_rdy, busy
  );

  modport slave (
    input  wr_vld, wr_rs, wr_data,
    output wr_rdy, busy
  );

endinterface

// File: rtl/lcd_init_rom.sv
// rtl/lcd_init_rom.sv - power-on command table for the LCD controller
module lcd_init_rom
  import lcd_pkg::*;
(
  input  logic [2:0] index,
  output logic [7:0] cmd
);

  always_comb begin
    cmd = CMD_FUNC_8B2L;
    case (index)
      3'd0, 3'd1, 3'd2: cmd = CMD_FUNC_8B2L;
      3'd3:             cmd = CMD_DISP_ON;
      3'd4:             cmd = CMD_CLEAR;
      3'd5:             cmd = CMD_ENTRY_INC;
      default:          cmd = CMD_FUNC_8B2L;
    endcase
  end

endmodule

// File: rtl/lcd_ctrl.sv
// rtl/lcd_ctrl.sv - HD44780 8-bit write sequencer with busy status
// Optional power-on init sequence enabled by defining LCD_INIT_EN.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int T_SETUP_CYC = 2,
  parameter int T_EN_CYC    = 12,
  parameter int T_HOLD_CYC  = 2,
  parameter int T_EXEC_CYC  = 1850,
  parameter int T_CLR_CYC   = 76000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  lcd_ctrl_if.slave   wr,
  output logic        o_lcd_on,
  output logic        o_lcd_en,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic [7:0]  o_lcd_data
);

  localparam int T_MAX = max_of(max_of(max_of(T_SETUP_CYC, T_EN_CYC),
                                       max_of(T_HOLD_CYC, T_EXEC_CYC)), T_CLR_CYC);
  localparam int CW = $clog2(T_MAX) + 1;

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t LD_SETUP = cnt_t'(T_SETUP_CYC - 1);
  localparam cnt_t LD_EN    = cnt_t'(T_EN_CYC - 1);
  localparam cnt_t LD_HOLD  = cnt_t'(T_HOLD_CYC - 1);
  localparam cnt_t LD_EXEC  = cnt_t'(T_EXEC_CYC - 1);
  localparam cnt_t LD_CLR   = cnt_t'(T_CLR_CYC - 1);

  lcd_state_e state, state_n;
  cnt_t       cnt, cnt_n;
  logic       en_q, en_n;
  logic       rs_q, rs_n;
  logic [7:0] data_q, data_n;
  logic       rdy_q, rdy_n;
  logic       cnt_done;

`ifdef LCD_INIT_EN
  logic [2:0] init_idx, init_idx_n;
  logic       init_pend, init_pend_n;
  logic [7:0] rom_cmd;

  lcd_init_rom u_init_rom (
    .index (init_idx),
    .cmd   (rom_cmd)
  );
`endif

  assign cnt_done = (cnt == '0);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    en_n    = 1'b0;
    rs_n    = rs_q;
    data_n  = data_q;
    rdy_n   = rdy_q;
`ifdef LCD_INIT_EN
    init_idx_n  = init_idx;
    init_pend_n = init_pend;
`endif

    case (state)
      IDLE: begin
`ifdef LCD_INIT_EN
        if (init_pend) begin
          state_n = INIT_WAIT;
          cnt_n   = LD_CLR;
        end else
`endif
        if (wr.wr_vld && rdy_q) begin
          state_n = SETUP;
          cnt_n   = LD_SETUP;
          rs_n    = wr.wr_rs;
          data_n  = wr.wr_data;
          rdy_n   = 1'b0;
        end
      end

      SETUP: begin
        if (cnt_done) begin
          state_n = PULSE;
          cnt_n   = LD_EN;
          en_n    = 1'b1;
        end else begin
          cnt_n = cnt - cnt_t'(1);
        end
      end

      PULSE: begin
        if (cnt_done) begin
          state_n = HOLD;
          cnt_n   = LD_HOLD;
        end else begin
          en_n  = 1'b1;
          cnt_n = cnt - cnt_t'(1);
        end
      end

      HOLD: begin
        if (cnt_done) begin
          state_n = EXEC;
          cnt_n   = is_long_cmd(rs_q, data_q) ? LD_CLR : LD_EXEC;
        end else begin
          cnt_n = cnt - cnt_t'(1);
        end
      end

      EXEC: begin
        if (cnt_done) begin
`ifdef LCD_INIT_EN
          // Init commands chain straight into the next SETUP with no idle cycle.
          if (init_pend && (init_idx != 3'(INIT_LEN))) begin
            state_n    = SETUP;
            cnt_n      = LD_SETUP;
            rs_n       = 1'b0;
            data_n     = rom_cmd;
            init_idx_n = init_idx + 3'd1;
          end else begin
            init_pend_n = 1'b0;
            state_n     = IDLE;
            rdy_n       = 1'b1;
          end
`else
          state_n = IDLE;
          rdy_n   = 1'b1;
`endif
        end else begin
          cnt_n = cnt - cnt_t'(1);
        end
      end

`ifdef LCD_INIT_EN
      INIT_WAIT: begin
        if (cnt_done) begin
          state_n    = SETUP;
          cnt_n      = LD_SETUP;
          rs_n       = 1'b0;
          data_n     = rom_cmd;
          init_idx_n = init_idx + 3'd1;
        end else begin
          cnt_n = cnt - cnt_t'(1);
        end
      end
`endif

      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      cnt    <= '0;
      en_q   <= 1'b0;
      rs_q   <= 1'b0;
      data_q <= 8'd0;
`ifdef LCD_INIT_EN
      rdy_q     <= 1'b0;
      init_idx  <= 3'd0;
      init_pend <= 1'b1;
`else
      rdy_q  <= 1'b1;
`endif
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      en_q   <= en_n;
      rs_q   <= rs_n;
      data_q <= data_n;
      rdy_q  <= rdy_n;
`ifdef LCD_INIT_EN
      init_idx  <= init_idx_n;
      init_pend <= init_pend_n;
`endif
    end
  end

  assign wr.wr_rdy  = rdy_q;
  assign wr.busy    = ~rdy_q;
  assign o_lcd_on   = 1'b1;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_en   = en_q;
  assign o_lcd_rs   = rs_q;
  assign o_lcd_data = data_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb/tb_lcd_ctrl.sv - randomized and directed checks of lcd_ctrl against a transfer-level model
module tb_lcd_ctrl;

  localparam int T_S   = 2;
  localparam int T_EN  = 3;
  localparam int T_H   = 1;
  localparam int T_X   = 5;
  localparam int T_CLR = 20;

`ifdef LCD_INIT_EN
  localparam bit INIT_MODE = 1'b1;
`else
  localparam bit INIT_MODE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw;
  logic [7:0] o_lcd_data;

  lcd_ctrl_if wr ();

  always #5 clk = ~clk;

  lcd_ctrl #(
    .T_SETUP_CYC (T_S),
    .T_EN_CYC    (T_EN),
    .T_HOLD_CYC  (T_H),
    .T_EXEC_CYC  (T_X),
    .T_CLR_CYC   (T_CLR)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .wr         (wr),
    .o_lcd_on   (o_lcd_on),
    .o_lcd_en   (o_lcd_en),
    .o_lcd_rs   (o_lcd_rs),
    .o_lcd_rw   (o_lcd_rw),
    .o_lcd_data (o_lcd_data)
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at edge", tag, got, exp);
    end
  endtask

  // Transfer-level model: each accepted byte owns a window of edges.
  logic [7:0] init_cmds [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
  int         edge_n = 0;
  bit         m_rdy, m_valid, init_on;
  int         m_start, m_end, init_idx, init_at;
  logic       m_rs;
  logic [7:0] m_data;

  function automatic int xfer_len(input logic rs, input logic [7:0] d);
    bit long_wait = (rs == 1'b0) && (d >= 8'd1) && (d <= 8'd3);
    return T_S + T_EN + T_H + (long_wait ? T_CLR : T_X);
  endfunction

  task automatic m_begin(input logic rs, input logic [7:0] d);
    m_valid = 1'b1;
    m_start = edge_n;
    m_end   = edge_n + xfer_len(rs, d);
    m_rs    = rs;
    m_data  = d;
    m_rdy   = 1'b0;
  endtask

  task automatic model_edge(input bit r, input bit v, input logic rs, input logic [7:0] d);
    bit acc;
    if (r) begin
      m_valid  = 1'b0;
      m_rs     = 1'b0;
      m_data   = 8'd0;
      m_rdy    = !INIT_MODE;
      init_on  = INIT_MODE;
      init_idx = 0;
      init_at  = edge_n + 1 + T_CLR;
    end else begin
      acc = m_rdy && v;
      if (m_valid && edge_n == m_end) begin
        m_valid = 1'b0;
        if (init_on && init_idx < 6) begin
          m_begin(1'b0, init_cmds[init_idx]);
          init_idx++;
        end else begin
          init_on = 1'b0;
          m_rdy   = 1'b1;
        end
      end else if (acc) begin
        m_begin(rs, d);
      end else if (init_on && !m_valid && init_idx == 0 && edge_n == init_at) begin
        m_begin(1'b0, init_cmds[0]);
        init_idx = 1;
      end
    end
  endtask

  task automatic step(input bit r, input bit v, input logic rs, input logic [7:0] d);
    bit exp_en;
    rst        = r;
    wr.wr_vld  = v;
    wr.wr_rs   = rs;
    wr.wr_data = d;
    @(posedge clk);
    edge_n++;
    model_edge(r, v, rs, d);
    #1;
    exp_en = m_valid && (edge_n >= m_start + T_S) && (edge_n < m_start + T_S + T_EN);
    check("en",   32'(o_lcd_en),   32'(exp_en));
    check("rdy",  32'(wr.wr_rdy),  32'(m_rdy));
    check("busy", 32'(wr.busy),    32'(!m_rdy));
    check("rs",   32'(o_lcd_rs),   32'(m_rs));
    check("data", 32'(o_lcd_data), 32'(m_data));
    check("rw",   32'(o_lcd_rw),   32'd0);
    check("on",   32'(o_lcd_on),   32'd1);
  endtask

  task automatic wait_model_ready();
    for (int k = 0; k < 400 && !m_rdy; k++) step(1'b0, 1'b0, 1'b0, 8'd0);
    check("ready_after_reset", 32'(wr.wr_rdy), 32'd1);
  endtask

  task automatic xfer(input logic rs, input logic [7:0] d,
                      output int lat, output int en_first, output int en_len,
                      output logic [7:0] en_data);
    int  a;
    bit  done = 1'b0;
    check("acc_rdy", 32'(wr.wr_rdy), 32'd1);
    step(1'b0, 1'b1, rs, d);
    a = edge_n;
    en_first = -1;
    en_len = 0;
    en_data = 8'd0;
    lat = -1;
    for (int k = 0; k < 200 && !done; k++) begin
      step(1'b0, 1'b0, 1'b0, 8'd0);
      if (o_lcd_en) begin
        if (en_first < 0) begin
          en_first = edge_n - a;
          en_data = o_lcd_data;
        end
        en_len++;
      end
      if (wr.wr_rdy) begin
        lat = edge_n - a;
        done = 1'b1;
      end
    end
    if (!done) check("xfer_timeout", 32'(wr.wr_rdy), 32'd1);
  endtask

  logic [7:0] dir_bytes [6] = '{8'h01, 8'h02, 8'h00, 8'h80, 8'h03, 8'h04};
  int         dir_lat   [6] = '{26, 26, 11, 11, 26, 11};

  initial begin
    int lat, ef, el, a1, a2, rise2;
    logic [7:0] ed;
    logic prev_en;
    logic [7:0] seen [$];

    rst = 1'b1;
    wr.wr_vld = 1'b0;
    wr.wr_rs = 1'b0;
    wr.wr_data = 8'd0;

    step(1'b1, 1'b0, 1'b0, 8'd0);
    check("reset_en",   32'(o_lcd_en),   32'd0);
    check("reset_data", 32'(o_lcd_data), 32'd0);
    check("reset_rdy",  32'(wr.wr_rdy),  32'(!INIT_MODE));

`ifdef LCD_INIT_EN
    prev_en = 1'b0;
    for (int k = 0; k < 400 && !wr.wr_rdy; k++) begin
      step(1'b0, 1'b0, 1'b0, 8'd0);
      if (o_lcd_en && !prev_en) begin
        seen.push_back(o_lcd_data);
        check("init_rs", 32'(o_lcd_rs), 32'd0);
      end
      prev_en = o_lcd_en;
    end
    check("init_count", 32'(seen.size()), 32'd6);
    for (int i = 0; i < 6 && i < seen.size(); i++) check("init_cmd", 32'(seen[i]), 32'(init_cmds[i]));
    check("init_rdy", 32'(wr.wr_rdy), 32'd1);
`endif
    wait_model_ready();

    // Plain data byte.
    xfer(1'b1, 8'h41, lat, ef, el, ed);
    check("t1_lat", 32'(lat), 32'd11);
    check("t1_en_first", 32'(ef), 32'd2);
    check("t1_en_len", 32'(el), 32'd3);
    check("t1_en_data", 32'(ed), 32'h41);

    // Long versus normal command waits.
    for (int i = 0; i < 6; i++) begin
      xfer(1'b0, dir_bytes[i], lat, ef, el, ed);
      check("t2_lat", 32'(lat), 32'(dir_lat[i]));
      check("t2_en_first", 32'(ef), 32'd2);
      check("t2_en_len", 32'(el), 32'd3);
    end

    // Pending request held across a busy transfer.
    step(1'b0, 1'b1, 1'b1, 8'h41);
    a1 = edge_n;
    a2 = -1;
    rise2 = -1;
    prev_en = o_lcd_en;
    for (int k = 0; k < 40 && rise2 < 0; k++) begin
      step(1'b0, 1'b1, 1'b1, 8'h5A);
      if (a2 < 0 && o_lcd_data == 8'h5A) a2 = edge_n;
      if (a2 >= 0 && o_lcd_en && !prev_en) rise2 = edge_n;
      prev_en = o_lcd_en;
    end
    check("t3_accept_gap", 32'(a2 - a1), 32'd12);
    check("t3_en_rise", 32'(rise2 - a2), 32'd2);
    for (int k = 0; k < 40 && !wr.wr_rdy; k++) step(1'b0, 1'b0, 1'b0, 8'd0);

    // Reset in the middle of the enable pulse.
    step(1'b0, 1'b1, 1'b1, 8'h33);
    for (int k = 0; k < T_S + 1; k++) step(1'b0, 1'b0, 1'b0, 8'd0);
    check("t4_in_pulse", 32'(o_lcd_en), 32'd1);
    step(1'b1, 1'b0, 1'b0, 8'd0);
    check("t4_en", 32'(o_lcd_en), 32'd0);
    check("t4_rdy", 32'(wr.wr_rdy), 32'(!INIT_MODE));
    if (!INIT_MODE) begin
      for (int k = 0; k < 30; k++) step(1'b0, 1'b0, 1'b0, 8'd0);
    end
    wait_model_ready();

    // Random traffic with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      logic [7:0] d;
      logic [7:0] picks [7];
      picks = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h80, 8'hFF};
      d = ($urandom_range(1) == 0) ? picks[$urandom_range(6)] : 8'($urandom);
      step($urandom_range(399) == 0, $urandom_range(1) == 1, 1'($urandom_range(1)), d);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
